alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one multi-cycle ALU between two requesters. A round-robin grant picks
// one pending operation in IDLE and registers its operands and opcode toward
// the ALU. It then pulses alu_start for one cycle and waits LATENCY cycles.
// Next it captures the ALU result and presents it to the owning requester
// until that requester consumes it.
//
// Parameters
//   Word_Length  operand/result width in bits
//   LATENCY      cycles from ALU issue to result sampling (legal range 1..15)
//
// Ports
//   clk                          sole clock, rising edge
//   reset                        synchronous, active-low reset
//   req0_valid / req1_valid      requester n has an operation pending
//   req0_ready / req1_ready      operation of requester n accepted this cycle
//   req0_A, req0_B, req0_Control operands/opcode of requester 0
//   req1_A, req1_B, req1_Control operands/opcode of requester 1
//   alu_A, alu_B, alu_Control    operands/opcode driven to the shared ALU
//   alu_start                    one-cycle issue strobe to the ALU
//   alu_C, alu_Carry             ALU result and carry/overflow
//   resp0_valid / resp1_valid    result available for requester n
//   resp0_ready / resp1_ready    requester n consumes the result
//   resp_C, resp_Carry           captured result, shared by both responders
//   busy                         high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int Word_Length = 6,
    parameter int LATENCY     = 2
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [Word_Length-1:0] req0_A,
    input  logic [Word_Length-1:0] req0_B,
    input  logic [3:0]             req0_Control,

    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [Word_Length-1:0] req1_A,
    input  logic [Word_Length-1:0] req1_B,
    input  logic [3:0]             req1_Control,

    output logic [Word_Length-1:0] alu_A,
    output logic [Word_Length-1:0] alu_B,
    output logic [3:0]             alu_Control,
    output logic                   alu_start,
    input  logic [Word_Length-1:0] alu_C,
    input  logic                   alu_Carry,

    output logic                   resp0_valid,
    input  logic                   resp0_ready,
    output logic                   resp1_valid,
    input  logic                   resp1_ready,
    output logic [Word_Length-1:0] resp_C,
    output logic                   resp_Carry,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } stateT;

    // Down-counter reload value; 4 bits covers the full 1..15 range.
    localparam logic [3:0] LatLoad = 4'(LATENCY);

    stateT                  stateReg;
    logic                   rrPtrReg;       // index of the requester favoured on contention
    logic                   ownerReg;       // requester whose operation is in flight
    logic [3:0]             countReg;
    logic [Word_Length-1:0] aluAReg;
    logic [Word_Length-1:0] aluBReg;
    logic [3:0]             aluCtlReg;
    logic                   aluStartReg;
    logic [Word_Length-1:0] respCReg;
    logic                   respCarryReg;
    logic [1:0]             respValidReg;
    logic                   busyReg;

    // Per-requester views so the grant logic can be written once.
    logic [1:0]             reqValid;
    logic [1:0]             respReady;
    logic [1:0]             grant;
    logic [Word_Length-1:0] reqA   [2];
    logic [Word_Length-1:0] reqB   [2];
    logic [3:0]             reqCtl [2];

    assign reqValid  = {req1_valid, req0_valid};
    assign respReady = {resp1_ready, resp0_ready};
    assign reqA[0]   = req0_A;
    assign reqA[1]   = req1_A;
    assign reqB[0]   = req0_B;
    assign reqB[1]   = req1_B;
    assign reqCtl[0] = req0_Control;
    assign reqCtl[1] = req1_Control;

    // A requester is granted when it is the only one asking, or when both ask
    // and the pointer favours it. Ready is held low while reset is asserted so
    // a requester never sees an acceptance that the FSM would discard.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gGrant
            assign grant[gi] = reset && (stateReg == IDLE) && reqValid[gi] &&
                               (!reqValid[1-gi] || (rrPtrReg == 1'(gi)));
        end
    endgenerate

    logic winner;
    logic accept;
    logic respDone;

    assign winner   = grant[1];
    assign accept   = |grant;
    // respValidReg is only ever set for the owner, so a ready from the other
    // requester cannot complete the response.
    assign respDone = |(respValidReg & respReady);

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg     <= IDLE;
            rrPtrReg     <= 1'b0;
            ownerReg     <= 1'b0;
            countReg     <= 4'd0;
            aluAReg      <= '0;
            aluBReg      <= '0;
            aluCtlReg    <= 4'd0;
            aluStartReg  <= 1'b0;
            respCReg     <= '0;
            respCarryReg <= 1'b0;
            respValidReg <= 2'b00;
            busyReg      <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (accept) begin
                        // Operands stay registered until the next handshake.
                        aluAReg     <= reqA[winner];
                        aluBReg     <= reqB[winner];
                        aluCtlReg   <= reqCtl[winner];
                        ownerReg    <= winner;
                        rrPtrReg    <= ~winner;
                        aluStartReg <= 1'b1;
                        busyReg     <= 1'b1;
                        stateReg    <= ISSUE;
                    end
                end

                ISSUE: begin
                    aluStartReg <= 1'b0;
                    countReg    <= LatLoad;
                    stateReg    <= WAIT;
                end

                WAIT: begin
                    countReg <= countReg - 4'd1;
                    // Treating 0 like 1 keeps an out-of-range LATENCY from
                    // wrapping the counter and stalling for 16 cycles.
                    if (countReg <= 4'd1) begin
                        respCReg     <= alu_C;
                        respCarryReg <= alu_Carry;
                        respValidReg <= ownerReg ? 2'b10 : 2'b01;
                        stateReg     <= RESP;
                    end
                end

                RESP: begin
                    if (respDone) begin
                        respValidReg <= 2'b00;
                        busyReg      <= 1'b0;
                        stateReg     <= IDLE;
                    end
                end

                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign alu_A       = aluAReg;
    assign alu_B       = aluBReg;
    assign alu_Control = aluCtlReg;
    assign alu_start   = aluStartReg;
    assign resp0_valid = respValidReg[0];
    assign resp1_valid = respValidReg[1];
    assign resp_C      = respCReg;
    assign resp_Carry  = respCarryReg;
    assign busy        = busyReg;

endmodule
